arb_wrr_burst: RTL and testbench

ARB_WRR_BURST -- requirements
Module: arb_wrr_burst

---
 rtl/arb_wrr_burst.sv | 76 +++++++
 tb/tb_arb_wrr_burst.sv | 87 ++++++++
 2 files changed

// File: rtl/arb_wrr_burst.sv
// arb_wrr_burst: weighted round-robin burst arbiter with zero-bubble handoff
module arb_wrr_burst #(
   parameter int NUM_REQS_P = 4,
   parameter int WEIGHT_W_P = 4,
   localparam int ID_W = (NUM_REQS_P > 1) ? $clog2(NUM_REQS_P) : 1
) (
   input  logic                             clk_i,
   input  logic                             reset_i,
   input  logic [NUM_REQS_P-1:0]            reqs_i,
   input  logic [NUM_REQS_P*WEIGHT_W_P-1:0] weights_i,
   input  logic                             yumi_i,
   output logic [NUM_REQS_P-1:0]            grants_o,
   output logic                             grant_v_o,
   output logic [ID_W-1:0]                  grant_id_o,
   output logic                             last_o
);
   typedef enum logic {IDLE_S, OWN_S} state_e;
   state_e state_q, state_d;
   logic [ID_W-1:0] owner_q, owner_d, ptr_q, ptr_d, base, win_id, owner_inc;
   logic [WEIGHT_W_P-1:0] rem_q, rem_d, win_w, win_load;
   logic win_v, owner_req, done;
   int idx;
   assign owner_inc = (owner_q == ID_W'(NUM_REQS_P-1)) ? '0 : owner_q + ID_W'(1);
   assign owner_req = reqs_i[owner_q];
   assign grant_v_o = ~reset_i & (state_q == OWN_S) & owner_req;
   assign grants_o = grant_v_o ? (NUM_REQS_P'(1) << owner_q) : '0;
   assign grant_id_o = grant_v_o ? owner_q : '0;
   assign last_o = grant_v_o & (rem_q == WEIGHT_W_P'(1));
   assign done = ~owner_req | (yumi_i & (rem_q == WEIGHT_W_P'(1)));
   assign base = (state_q == OWN_S) ? owner_inc : ptr_q;
   assign win_w = weights_i[int'(win_id)*WEIGHT_W_P +: WEIGHT_W_P];
   assign win_load = (win_w == '0) ? WEIGHT_W_P'(1) : win_w;
   // round-robin search from base; scanning downward lets the closest index win
   always_comb begin
      win_v = 1'b0;
      win_id = '0;
      idx = 0;
      for (int i = NUM_REQS_P-1; i >= 0; i--) begin
         idx = int'(base) + i;
         if (idx >= NUM_REQS_P) idx = idx - NUM_REQS_P;
         if (reqs_i[idx]) begin
            win_v = 1'b1;
            win_id = ID_W'(idx);
         end
      end
   end
   // next state: latch a new owner from IDLE or on ownership end, else count accepted beats
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      rem_d = rem_q;
      ptr_d = ptr_q;
      if (state_q == IDLE_S || done) begin
         ptr_d = (state_q == OWN_S) ? owner_inc : ptr_q;
         state_d = win_v ? OWN_S : IDLE_S;
         owner_d = win_v ? win_id : owner_q;
         rem_d = win_v ? win_load : rem_q;
      end else if (yumi_i && grant_v_o) begin
         rem_d = rem_q - WEIGHT_W_P'(1);
      end
   end
   // state registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE_S;
         owner_q <= '0;
         rem_q <= '0;
         ptr_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         rem_q <= rem_d;
         ptr_q <= ptr_d;
      end
   end
endmodule

// File: tb/tb_arb_wrr_burst.sv
// tb_arb_wrr_burst: directed checks of the weighted round-robin burst arbiter
module tb_arb_wrr_burst;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic yumi = 1'b0;
   logic [3:0] reqs = '0;
   logic [15:0] weights = 16'h1111;
   logic [3:0] grants;
   logic grant_v, last;
   logic [1:0] gid;
   int total = 0;
   int bad = 0;
   always #5 clk = ~clk;
   arb_wrr_burst #(.NUM_REQS_P(4), .WEIGHT_W_P(4)) dut (
      .clk_i(clk), .reset_i(reset), .reqs_i(reqs), .weights_i(weights), .yumi_i(yumi),
      .grants_o(grants), .grant_v_o(grant_v), .grant_id_o(gid), .last_o(last)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask
   task automatic cyc(input logic r, input logic [3:0] q, input logic y);
      @(negedge clk);
      reset = r;
      reqs = q;
      yumi = y;
      #1;
   endtask
   task automatic expect_g(input string tag, input logic [3:0] g, input logic [1:0] id, input logic l);
      chk({tag, "_g"}, 32'(grants), 32'(g));
      chk({tag, "_v"}, 32'(grant_v), 32'(|g));
      chk({tag, "_id"}, 32'(gid), 32'(id));
      chk({tag, "_last"}, 32'(last), 32'(l));
   endtask
   initial begin
      weights = 16'h1111;
      cyc(1, 4'hF, 1); expect_g("rst0", 0, 0, 0);
      cyc(1, 4'hF, 1); expect_g("rst1", 0, 0, 0);
      cyc(0, 4'hF, 1); expect_g("idle", 0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         cyc(0, 4'hF, 1); expect_g("rr", 4'(1 << (i % 4)), 2'(i % 4), 1);
      end
      weights = 16'h1123;
      cyc(1, 4'b0011, 1); expect_g("w_rst", 0, 0, 0);
      cyc(0, 4'b0011, 1); expect_g("w_idle", 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         cyc(0, 4'b0011, 1);
         expect_g("wrr", (i % 5 < 3) ? 4'b0001 : 4'b0010, (i % 5 < 3) ? 2'd0 : 2'd1, (i % 5 == 2) || (i % 5 == 4));
      end
      weights = 16'h1114;
      cyc(1, 4'b0000, 1); expect_g("d_rst", 0, 0, 0);
      cyc(0, 4'b0000, 1); expect_g("d_noreq0", 0, 0, 0);
      cyc(0, 4'b0000, 1); expect_g("d_noreq1", 0, 0, 0);
      cyc(0, 4'b0101, 1); expect_g("d_idle", 0, 0, 0);
      cyc(0, 4'b0101, 1); expect_g("d_own0", 4'b0001, 0, 0);
      cyc(0, 4'b0100, 1); expect_g("d_drop", 0, 0, 0);
      cyc(0, 4'b0100, 1); expect_g("d_own2", 4'b0100, 2, 1);
      chk("d_ptr", 32'(dut.ptr_q), 1);
      weights = 16'h1131;
      cyc(1, 4'b0010, 0); expect_g("s_rst", 0, 0, 0);
      cyc(0, 4'b0010, 0); expect_g("s_idle", 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         if (i == 4) weights = 16'hFFFF;
         cyc(0, 4'b0010, 0); expect_g("stall", 4'b0010, 1, 0);
      end
      chk("s_rem", 32'(dut.rem_q), 3);
      cyc(0, 4'b0010, 1); expect_g("s_b1", 4'b0010, 1, 0);
      cyc(0, 4'b0010, 1); expect_g("s_b2", 4'b0010, 1, 0);
      cyc(0, 4'b0010, 1); expect_g("s_b3", 4'b0010, 1, 1);
      cyc(0, 4'b0010, 1); expect_g("s_fresh", 4'b0010, 1, 0);
      chk("s_rem_new", 32'(dut.rem_q), 15);
      weights = 16'h1311;
      cyc(1, 4'b0101, 1); expect_g("r_rst", 0, 0, 0);
      cyc(0, 4'b0101, 1); expect_g("r_idle", 0, 0, 0);
      cyc(0, 4'b0101, 1); expect_g("r_own0", 4'b0001, 0, 1);
      cyc(0, 4'b0101, 1); expect_g("r_own2", 4'b0100, 2, 0);
      cyc(1, 4'b0101, 1); expect_g("r_mid0", 0, 0, 0);
      cyc(1, 4'b0101, 1); expect_g("r_mid1", 0, 0, 0);
      cyc(0, 4'b0101, 1); expect_g("r_idle2", 0, 0, 0);
      cyc(0, 4'b0101, 1); expect_g("r_first", 4'b0001, 0, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
